code_lock_ctrl: RTL and testbench
=================================

// Module: code_lock_ctrl
// PURPOSE
//  Parametrised controller for the keypad code lock.
//  Counts entered digits and drives the external digit shift register (shift/clear/load).
//  Checks the comparator result, tracks bad attempts and raises the alarm.
//  Holds the lock open for a timed window; a key press in that window enters code-programming mode.
//  All timing is synchronous to clk; there are no derived clocks.
// PARAMETERS
//  CODE_LEN      4           digits per code (1..15)
//  MAX_BAD       3           consecutive bad codes that raise alarm (1..15)
//  TICK_DIV      50_000_000  clk cycles per 1 s tick (>=2)
//  OPEN_SECS     10          lock-open window, seconds (>=1)
//  LOCKOUT_SECS  30          keypad lockout after alarm, seconds (LOCKOUT_EN only)
// PORTS
//  clk        in   1        clock
//  clr        in   1        reset: asynchronous, active-high
//  key        in   1        debounced single-cycle key strobe
//  pass_ok    in   1        comparator: shift register == stored code (valid in CHECK)
//  sr_shift   out  1        1-cycle pulse: shift current digit into register
//  sr_clear   out  1        1-cycle pulse: clear shift register
//  code_load  out  1        1-cycle pulse: copy shift register to stored code
//  digit_cnt  out  CNT_W    digits entered, CNT_W=$clog2(CODE_LEN+1)
//  bad_cnt    out  4        consecutive bad codes, saturates at MAX_BAD
//  alarm      out  1        alarm LED
//  lock_open  out  1        lock actuator
//  prog_mode  out  1        programming mode (LED blinks)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; timer idle. clr acts mid-operation and aborts any state or pulse.
//  States: IDLE, SHIFT, CHECK, STORE, OPEN (+LOCKOUT).
//  IDLE, key, digit_cnt<CODE_LEN: sr_shift=1 next cycle, digit_cnt+1, go SHIFT.
//  SHIFT: sr_shift=0, back to IDLE. Keys in SHIFT are ignored.
//  IDLE, key, digit_cnt==CODE_LEN: prog_mode ? STORE : CHECK.
//  CHECK: samples pass_ok exactly once.
//   ok: lock_open=1, bad_cnt=0, alarm=0, sr_clear pulse, digit_cnt=0; start timer; go OPEN.
//   bad: bad_cnt=min(bad_cnt+1,MAX_BAD); alarm=1 when the new value==MAX_BAD; sr_clear pulse; digit_cnt=0; go IDLE.
//   lock_open rises 2 cycles after the terminating key.
//  STORE: code_load pulse, sr_clear pulse, prog_mode=0, digit_cnt=0; go IDLE.
//  OPEN: timer counts OPEN_SECS*TICK_DIV cycles.
//   done: lock_open=0, go IDLE.
//   key: prog_mode=1, lock_open=0, timer aborted, go IDLE.
//   key and done in the same cycle: done wins; prog_mode stays 0.
//  alarm is cleared only by a correct code or clr. bad_cnt holds at MAX_BAD.
//  Programming never compares pass_ok and never touches bad_cnt or alarm.
//  No wrap-around: digit_cnt never exceeds CODE_LEN; keys in CHECK/STORE are ignored.
// CONFIGURATION
//  LOCKOUT_EN defined:
//   a bad code that sets alarm goes to LOCKOUT instead of IDLE.
//   LOCKOUT runs the timer for LOCKOUT_SECS*TICK_DIV cycles; all keys are ignored; digit_cnt stays 0.
//   On done: go IDLE with alarm still 1.
//  LOCKOUT_EN undefined: no LOCKOUT state, LOCKOUT_SECS unused; alarm bad code goes to IDLE.
// STRUCTURE
//  lock_pkg: state enum (IDLE,SHIFT,CHECK,STORE,OPEN,LOCKOUT), 3-bit state width, $clog2 helper.
//  Sub-module unlock_timer:
//   TICK_DIV prescaler plus seconds down-counter.
//   Ports: start (with secs load value), abort, busy, done (1-cycle pulse).
//   Shared by OPEN and LOCKOUT.
// TESTING  (bench: CODE_LEN=4, MAX_BAD=3, TICK_DIV=4, OPEN_SECS=3, LOCKOUT_SECS=2)
//  1. 4 keys -> four 1-cycle sr_shift, digit_cnt 1,2,3,4. 5th key with pass_ok=1 -> lock_open=1 two cycles later,
//     sr_clear pulse, digit_cnt=0. lock_open=0 after 12 cycles.
//  2. 3 bad codes -> bad_cnt 1,2,3, alarm=1 after the 3rd CHECK; 4th bad keeps bad_cnt=3.
//     Then a good code -> alarm=0, bad_cnt=0.
//  3. Key while OPEN -> prog_mode=1, lock_open=0. 4 digits + key -> single code_load pulse, prog_mode=0,
//     digit_cnt=0, bad_cnt unchanged.
//  4. Key on the same cycle as timer done -> lock_open=0, prog_mode=0.
//  5. clr pulse mid-SHIFT and mid-OPEN -> all outputs 0 immediately (async); next key counts from digit_cnt=1.
//  6. LOCKOUT_EN: 3rd bad code -> keys ignored for 8 cycles (digit_cnt=0, no sr_shift), alarm stays 1;
//     afterwards keys accepted.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad code lock controller.
// Holds the FSM state encoding and a constant ceil(log2) helper used for counter sizing.
package lock_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CHECK   = 3'd2,
        STORE   = 3'd3,
        OPEN    = 3'd4,
        LOCKOUT = 3'd5
    } lock_state_t;

    function automatic int lock_clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/unlock_timer.sv
// Seconds timer shared by the open window and the alarm lockout.
// A TICK_DIV prescaler feeds a seconds down-counter; done pulses during the final clk cycle.
module unlock_timer
    import lock_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int SECS_W   = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [SECS_W-1:0] secs,
    input  logic              abort,
    output logic              busy,
    output logic              done
);

    localparam int PRE_W = lock_clog2(TICK_DIV);

    logic [PRE_W-1:0]  pre_cnt;
    logic [SECS_W-1:0] sec_cnt;
    logic              pre_last;
    logic              sec_last;

    assign pre_last = (pre_cnt == PRE_W'(TICK_DIV - 1));
    assign sec_last = (sec_cnt <= SECS_W'(1));
    assign done     = busy && pre_last && sec_last;

    // Abort has priority over start so a key in the open window always stops the count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy    <= 1'b0;
            pre_cnt <= '0;
            sec_cnt <= '0;
        end else if (abort) begin
            busy    <= 1'b0;
            pre_cnt <= '0;
            sec_cnt <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            pre_cnt <= '0;
            sec_cnt <= secs;
        end else if (busy) begin
            if (pre_last) begin
                pre_cnt <= '0;
                if (sec_last) begin
                    busy <= 1'b0;
                end else begin
                    sec_cnt <= sec_cnt - SECS_W'(1);
                end
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code lock controller: digit entry, code check, bad-attempt alarm, timed open and programming.
// Optional keypad lockout after the alarm is enabled by defining LOCKOUT_EN.
module code_lock_ctrl
    import lock_pkg::*;
#(
    parameter  int CODE_LEN     = 4,
    parameter  int MAX_BAD      = 3,
    parameter  int TICK_DIV     = 50_000_000,
    parameter  int OPEN_SECS    = 10,
    parameter  int LOCKOUT_SECS = 30,
    localparam int CNT_W        = lock_clog2(CODE_LEN + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             key,
    input  logic             pass_ok,
    output logic             sr_shift,
    output logic             sr_clear,
    output logic             code_load,
    output logic [CNT_W-1:0] digit_cnt,
    output logic [3:0]       bad_cnt,
    output logic             alarm,
    output logic             lock_open,
    output logic             prog_mode
);

    // The timer is sized for the longer of the two windows so one instance serves both.
    localparam int MAX_SECS = (OPEN_SECS > LOCKOUT_SECS) ? OPEN_SECS : LOCKOUT_SECS;
    localparam int SECS_W   = lock_clog2(MAX_SECS + 1);

    lock_state_t       state, state_n;
    logic [CNT_W-1:0]  digit_n;
    logic [3:0]        bad_n;
    logic [3:0]        bad_inc;
    logic              alarm_n, lock_n, prog_n;
    logic              shift_n, clear_n, load_n;
    logic              tmr_start, tmr_abort, tmr_busy, tmr_done;
    logic [SECS_W-1:0] tmr_secs;

    unlock_timer #(
        .TICK_DIV (TICK_DIV),
        .SECS_W   (SECS_W)
    ) u_timer (
        .clk   (clk),
        .clr   (clr),
        .start (tmr_start),
        .secs  (tmr_secs),
        .abort (tmr_abort),
        .busy  (tmr_busy),
        .done  (tmr_done)
    );

    assign bad_inc = (bad_cnt < 4'(MAX_BAD)) ? bad_cnt + 4'd1 : 4'(MAX_BAD);

    // All outputs are registered so every pulse is exactly one glitch-free clk cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            digit_cnt <= '0;
            bad_cnt   <= '0;
            alarm     <= 1'b0;
            lock_open <= 1'b0;
            prog_mode <= 1'b0;
            sr_shift  <= 1'b0;
            sr_clear  <= 1'b0;
            code_load <= 1'b0;
        end else begin
            state     <= state_n;
            digit_cnt <= digit_n;
            bad_cnt   <= bad_n;
            alarm     <= alarm_n;
            lock_open <= lock_n;
            prog_mode <= prog_n;
            sr_shift  <= shift_n;
            sr_clear  <= clear_n;
            code_load <= load_n;
        end
    end

    always_comb begin
        state_n   = state;
        digit_n   = digit_cnt;
        bad_n     = bad_cnt;
        alarm_n   = alarm;
        lock_n    = lock_open;
        prog_n    = prog_mode;
        shift_n   = 1'b0;
        clear_n   = 1'b0;
        load_n    = 1'b0;
        tmr_start = 1'b0;
        tmr_abort = 1'b0;
        tmr_secs  = SECS_W'(OPEN_SECS);

        case (state)
            IDLE: begin
                if (key) begin
                    if (digit_cnt < CNT_W'(CODE_LEN)) begin
                        shift_n = 1'b1;
                        digit_n = digit_cnt + CNT_W'(1);
                        state_n = SHIFT;
                    end else begin
                        state_n = prog_mode ? STORE : CHECK;
                    end
                end
            end
            SHIFT: begin
                state_n = IDLE;
            end
            CHECK: begin
                clear_n = 1'b1;
                digit_n = '0;
                if (pass_ok) begin
                    lock_n    = 1'b1;
                    bad_n     = '0;
                    alarm_n   = 1'b0;
                    tmr_start = 1'b1;
                    state_n   = OPEN;
                end else begin
                    bad_n   = bad_inc;
                    state_n = IDLE;
                    if (bad_inc == 4'(MAX_BAD)) begin
                        alarm_n = 1'b1;
`ifdef LOCKOUT_EN
                        tmr_start = 1'b1;
                        tmr_secs  = SECS_W'(LOCKOUT_SECS);
                        state_n   = LOCKOUT;
`endif
                    end
                end
            end
            STORE: begin
                load_n  = 1'b1;
                clear_n = 1'b1;
                prog_n  = 1'b0;
                digit_n = '0;
                state_n = IDLE;
            end
            // Timer expiry beats a simultaneous key, so programming is never entered at the edge.
            OPEN: begin
                if (tmr_done || !tmr_busy) begin
                    lock_n  = 1'b0;
                    state_n = IDLE;
                end else if (key) begin
                    prog_n    = 1'b1;
                    lock_n    = 1'b0;
                    tmr_abort = 1'b1;
                    state_n   = IDLE;
                end
            end
`ifdef LOCKOUT_EN
            LOCKOUT: begin
                if (tmr_done || !tmr_busy) begin
                    state_n = IDLE;
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed self-checking bench for code_lock_ctrl (CODE_LEN=4, MAX_BAD=3, TICK_DIV=4, OPEN_SECS=3).
// Define LOCKOUT_EN for both bench and RTL to exercise the keypad lockout path.
module tb_code_lock_ctrl;

    logic       clk;
    logic       clr;
    logic       key;
    logic       pass_ok;
    logic       sr_shift;
    logic       sr_clear;
    logic       code_load;
    logic [2:0] digit_cnt;
    logic [3:0] bad_cnt;
    logic       alarm;
    logic       lock_open;
    logic       prog_mode;

    int errors;
    int checks;

    code_lock_ctrl #(
        .CODE_LEN     (4),
        .MAX_BAD      (3),
        .TICK_DIV     (4),
        .OPEN_SECS    (3),
        .LOCKOUT_SECS (2)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .key       (key),
        .pass_ok   (pass_ok),
        .sr_shift  (sr_shift),
        .sr_clear  (sr_clear),
        .code_load (code_load),
        .digit_cnt (digit_cnt),
        .bad_cnt   (bad_cnt),
        .alarm     (alarm),
        .lock_open (lock_open),
        .prog_mode (prog_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic press_key();
        key = 1'b1;
        tick();
        key = 1'b0;
    endtask

    task automatic press_digits(input int n);
        repeat (n) begin
            press_key();
            tick();
        end
    endtask

    task automatic submit(input logic ok);
        pass_ok = ok;
        press_key();
        tick();
        pass_ok = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        key = 1'b0;
        pass_ok = 1'b0;
        wait_cycles(3);
        checks++; if ({sr_shift, sr_clear, code_load} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses: got %b want 000", {sr_shift, sr_clear, code_load}); end
        checks++; if (digit_cnt !== 3'd0 || bad_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_counts: got digit=%0d bad=%0d want 0 0", digit_cnt, bad_cnt); end
        checks++; if ({alarm, lock_open, prog_mode} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b want 000", {alarm, lock_open, prog_mode}); end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_open();
        for (int i = 1; i <= 4; i++) begin
            press_key();
            checks++; if (sr_shift !== 1'b1 || digit_cnt !== 3'(i)) begin errors++; $display("[TB] FAIL open_shift%0d: got shift=%b digit=%0d want 1 %0d", i, sr_shift, digit_cnt, i); end
            tick();
            checks++; if (sr_shift !== 1'b0) begin errors++; $display("[TB] FAIL open_shift_end%0d: got %b want 0", i, sr_shift); end
        end
        pass_ok = 1'b1;
        press_key();
        checks++; if (lock_open !== 1'b0) begin errors++; $display("[TB] FAIL open_early: got %b want 0", lock_open); end
        tick();
        pass_ok = 1'b0;
        checks++; if (lock_open !== 1'b1 || sr_clear !== 1'b1 || digit_cnt !== 3'd0) begin errors++; $display("[TB] FAIL open_rise: got lock=%b clear=%b digit=%0d want 1 1 0", lock_open, sr_clear, digit_cnt); end
        tick();
        checks++; if (sr_clear !== 1'b0) begin errors++; $display("[TB] FAIL open_clear_pulse: got %b want 0", sr_clear); end
        wait_cycles(10);
        checks++; if (lock_open !== 1'b1) begin errors++; $display("[TB] FAIL open_hold: got %b want 1", lock_open); end
        tick();
        checks++; if (lock_open !== 1'b0) begin errors++; $display("[TB] FAIL open_close: got %b want 0", lock_open); end
    endtask

    task automatic test_bad_codes();
        for (int i = 1; i <= 3; i++) begin
            press_digits(4);
            submit(1'b0);
            checks++; if (bad_cnt !== 4'(i)) begin errors++; $display("[TB] FAIL bad_cnt%0d: got %0d want %0d", i, bad_cnt, i); end
            checks++; if (alarm !== (i == 3)) begin errors++; $display("[TB] FAIL bad_alarm%0d: got %b want %b", i, alarm, (i == 3)); end
            checks++; if (lock_open !== 1'b0 || digit_cnt !== 3'd0) begin errors++; $display("[TB] FAIL bad_state%0d: got lock=%b digit=%0d want 0 0", i, lock_open, digit_cnt); end
        end
    endtask

`ifdef LOCKOUT_EN
    task automatic test_lockout();
        for (int i = 0; i < 8; i++) begin
            key = 1'b1;
            tick();
            checks++; if (digit_cnt !== 3'd0 || sr_shift !== 1'b0 || alarm !== 1'b1) begin errors++; $display("[TB] FAIL lockout_key%0d: got digit=%0d shift=%b alarm=%b want 0 0 1", i, digit_cnt, sr_shift, alarm); end
        end
        key = 1'b0;
        press_key();
        checks++; if (digit_cnt !== 3'd1 || sr_shift !== 1'b1) begin errors++; $display("[TB] FAIL lockout_release: got digit=%0d shift=%b want 1 1", digit_cnt, sr_shift); end
        tick();
        press_digits(3);
        submit(1'b0);
        checks++; if (bad_cnt !== 4'd3 || alarm !== 1'b1) begin errors++; $display("[TB] FAIL bad_saturate: got bad=%0d alarm=%b want 3 1", bad_cnt, alarm); end
        wait_cycles(8);
    endtask
`else
    task automatic test_no_lockout();
        press_key();
        checks++; if (digit_cnt !== 3'd1 || sr_shift !== 1'b1) begin errors++; $display("[TB] FAIL alarm_key_accept: got digit=%0d shift=%b want 1 1", digit_cnt, sr_shift); end
        tick();
        press_digits(3);
        submit(1'b0);
        checks++; if (bad_cnt !== 4'd3 || alarm !== 1'b1) begin errors++; $display("[TB] FAIL bad_saturate: got bad=%0d alarm=%b want 3 1", bad_cnt, alarm); end
    endtask
`endif

    task automatic test_good_after_alarm();
        press_digits(4);
        submit(1'b1);
        checks++; if (alarm !== 1'b0 || bad_cnt !== 4'd0) begin errors++; $display("[TB] FAIL good_clears: got alarm=%b bad=%0d want 0 0", alarm, bad_cnt); end
        checks++; if (lock_open !== 1'b1 || sr_clear !== 1'b1) begin errors++; $display("[TB] FAIL good_open: got lock=%b clear=%b want 1 1", lock_open, sr_clear); end
    endtask

    task automatic test_program();
        press_key();
        checks++; if (prog_mode !== 1'b1 || lock_open !== 1'b0) begin errors++; $display("[TB] FAIL prog_enter: got prog=%b lock=%b want 1 0", prog_mode, lock_open); end
        press_digits(4);
        checks++; if (digit_cnt !== 3'd4 || code_load !== 1'b0) begin errors++; $display("[TB] FAIL prog_digits: got digit=%0d load=%b want 4 0", digit_cnt, code_load); end
        pass_ok = 1'b0;
        press_key();
        checks++; if (code_load !== 1'b0) begin errors++; $display("[TB] FAIL prog_load_early: got %b want 0", code_load); end
        tick();
        checks++; if (code_load !== 1'b1 || sr_clear !== 1'b1) begin errors++; $display("[TB] FAIL prog_load: got load=%b clear=%b want 1 1", code_load, sr_clear); end
        checks++; if (prog_mode !== 1'b0 || digit_cnt !== 3'd0) begin errors++; $display("[TB] FAIL prog_exit: got prog=%b digit=%0d want 0 0", prog_mode, digit_cnt); end
        checks++; if (bad_cnt !== 4'd0 || alarm !== 1'b0 || lock_open !== 1'b0) begin errors++; $display("[TB] FAIL prog_no_check: got bad=%0d alarm=%b lock=%b want 0 0 0", bad_cnt, alarm, lock_open); end
        tick();
        checks++; if (code_load !== 1'b0) begin errors++; $display("[TB] FAIL prog_load_pulse: got %b want 0", code_load); end
    endtask

    task automatic test_done_and_key();
        press_digits(4);
        submit(1'b1);
        wait_cycles(11);
        checks++; if (lock_open !== 1'b1) begin errors++; $display("[TB] FAIL race_hold: got %b want 1", lock_open); end
        press_key();
        checks++; if (lock_open !== 1'b0 || prog_mode !== 1'b0) begin errors++; $display("[TB] FAIL race_done_wins: got lock=%b prog=%b want 0 0", lock_open, prog_mode); end
        tick();
        checks++; if (prog_mode !== 1'b0 || digit_cnt !== 3'd0) begin errors++; $display("[TB] FAIL race_after: got prog=%b digit=%0d want 0 0", prog_mode, digit_cnt); end
    endtask

    task automatic test_clr_async();
        press_key();
        #2;
        clr = 1'b1;
        #1;
        checks++; if (sr_shift !== 1'b0 || digit_cnt !== 3'd0) begin errors++; $display("[TB] FAIL clr_shift: got shift=%b digit=%0d want 0 0", sr_shift, digit_cnt); end
        tick();
        clr = 1'b0;
        press_key();
        checks++; if (digit_cnt !== 3'd1) begin errors++; $display("[TB] FAIL clr_restart1: got %0d want 1", digit_cnt); end
        tick();
        press_digits(3);
        submit(1'b1);
        wait_cycles(3);
        checks++; if (lock_open !== 1'b1) begin errors++; $display("[TB] FAIL clr_open_pre: got %b want 1", lock_open); end
        #2;
        clr = 1'b1;
        #1;
        checks++; if ({sr_shift, sr_clear, code_load, alarm, lock_open, prog_mode} !== 6'b0 || digit_cnt !== 3'd0 || bad_cnt !== 4'd0) begin errors++; $display("[TB] FAIL clr_open: got flags=%b digit=%0d bad=%0d want 0", {sr_shift, sr_clear, code_load, alarm, lock_open, prog_mode}, digit_cnt, bad_cnt); end
        tick();
        clr = 1'b0;
        press_key();
        checks++; if (digit_cnt !== 3'd1 || lock_open !== 1'b0) begin errors++; $display("[TB] FAIL clr_restart2: got digit=%0d lock=%b want 1 0", digit_cnt, lock_open); end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_open();
        test_bad_codes();
`ifdef LOCKOUT_EN
        test_lockout();
`else
        test_no_lockout();
`endif
        test_good_after_alarm();
        test_program();
        test_done_and_key();
        test_clr_async();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
